pipeline_hazard_ctrl: RTL
=========================

Name: pipeline_hazard_ctrl

Overview:
- Central stall/flush controller for the 5-stage MIPS pipeline.
- Detects ID-stage data hazards and taken-branch redirects, and sequences a multi-cycle data-memory access.
- Produces the Freeze/flush/bubble controls for the IF/ID, ID/EXE, EXE/MEM and MEM/WB stage registers and the PC.
- Keeps saturating performance counters for stall and flush cycles.

Parameters:
- MEM_LATENCY, 4, stall cycles per data-memory access (legal range 1..15).
- CNT_W, 16, width of each performance counter.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  reset, asynchronous, active-high.
- id_src1  in  5  ID-stage source register 1.
- id_src2  in  5  ID-stage source register 2.
- id_two_src  in  1  ID instruction reads id_src2 (R-type, store, branch-compare).
- exe_dest  in  5  EXE-stage destination register.
- exe_wb_en  in  1  EXE-stage instruction writes back.
- exe_mem_r_en  in  1  EXE-stage instruction is a load.
- mem_dest  in  5  MEM-stage destination register.
- mem_wb_en  in  1  MEM-stage instruction writes back.
- forward_en  in  1  forwarding unit enabled.
- branch_taken  in  1  EXE-stage branch/jump resolved taken.
- mem_req  in  1  MEM-stage instruction accesses data memory (load or store).
- freeze_if  out  1  hold PC and IF/ID register.
- freeze_id  out  1  hold ID/EXE register.
- freeze_exe  out  1  hold EXE/MEM register.
- freeze_mem  out  1  hold MEM/WB register.
- bubble_id  out  1  load ID/EXE with a NOP (all control enables 0).
- flush_if  out  1  clear IF/ID register on the next edge.
- stall_cycles  out  CNT_W  count of cycles with freeze_if=1; saturates at all-ones.
- flush_count  out  CNT_W  count of cycles with flush_if=1; saturates at all-ones.

Behaviour:
- Reset: rst is asynchronous, active-high; clock is clk.
  - While rst=1: FSM=IDLE, latency counter=0, stall_cycles=0, flush_count=0.
  - While rst=1, all six control outputs are forced to 0 regardless of inputs.
  - Reset mid-access abandons the access; the first cycle after release is IDLE.
- Memory FSM states: IDLE, WAIT, DONE.
  - IDLE & mem_req: mem_stall=1 and the latency counter loads. Go to WAIT if MEM_LATENCY>1, else go to DONE.
  - WAIT: mem_stall=1, counter decrements. Move to DONE so that total mem_stall cycles (IDLE cycle + WAIT cycles) equal exactly MEM_LATENCY.
  - DONE: mem_stall=0 for one cycle, so the instruction leaves MEM at that edge. mem_req is ignored in DONE (same instruction). Go to IDLE unconditionally.
  - Back-to-back memory instructions: the next access starts in the IDLE cycle immediately after DONE. This gives MEM_LATENCY+1 cycles per access.
- Data hazard, combinational, ID stage:
  - A match means an id_src equals a destination, that destination is non-zero, and its wb_en is set. id_src2 is used only if id_two_src=1.
  - forward_en=0: hazard on a match against EXE or MEM.
  - forward_en=1: hazard only on a match against EXE with exe_mem_r_en=1 (load-use).
- Output priority, highest first:
  1. mem_stall: freeze_if=freeze_id=freeze_exe=freeze_mem=1; bubble_id=0, flush_if=0. Branch and hazard are ignored this cycle.
  2. branch_taken: flush_if=1, bubble_id=1, all freezes 0. Any data hazard is suppressed because the ID instruction is squashed.
  3. hazard: freeze_if=1, bubble_id=1; all other outputs 0.
  4. Otherwise all outputs 0.
- All control outputs are combinational from FSM state and inputs, with no registered latency. The pipeline registers act on them at the next posedge.
- Counters:
  - Increment at posedge when the corresponding output is 1.
  - Hold at 2^CNT_W-1.
  - Never wrap.

Decomposition:
- Shared package (mips_pkg) holds:
  - REG_ADDR_W=5 and the zero-register constant.
  - Memory FSM state typedef {IDLE, WAIT, DONE}.
- One natural sub-module: hazard_detect. It is the purely combinational src/dest compare, returning a hazard bit.
- The FSM, priority mux and counters stay in pipeline_hazard_ctrl.

Test Plan:
- Reset check: assert rst mid-WAIT with mem_req=1 and branch_taken=1 -> all outputs 0 immediately; after release FSM=IDLE, stall_cycles=0, flush_count=0.
- Load-use with forwarding: forward_en=1, exe_dest=5, exe_wb_en=1, exe_mem_r_en=1, id_src1=5 -> freeze_if=1, bubble_id=1 for one cycle. Repeat with exe_dest=0 -> no hazard.
- No forwarding: forward_en=0, mem_dest=7, mem_wb_en=1, id_two_src=1, id_src2=7 -> freeze_if=1, bubble_id=1. Same with id_two_src=0 -> no hazard.
- Memory access: MEM_LATENCY=4, mem_req held high for 2 consecutive instructions -> freeze_* high 4 cycles, low 1 cycle (DONE), high 4 cycles, low 1 cycle; stall_cycles=8.
- Priority: mem_req and branch_taken and hazard all asserted in IDLE -> only the four freezes =1 for MEM_LATENCY cycles. In the DONE cycle with branch_taken still 1 -> flush_if=1, bubble_id=1, freeze_if=0; flush_count increments by 1.
- Saturation: CNT_W=4, hold a hazard 20 cycles -> stall_cycles stops at 15.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared MIPS pipeline definitions: register-address width, the hard-wired
// zero register and the data-memory access FSM states.
package mips_pkg;

    localparam int REG_ADDR_W = 5;
    localparam logic [REG_ADDR_W-1:0] ZERO_REG = '0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } mem_state_t;

endpackage

// File: rtl/pipeline_hazard_ctrl_hazard_detect.sv
// ID-stage read-after-write hazard detector; compares the ID sources against
// the EXE and MEM destinations, honouring forwarding and load-use rules.
module hazard_detect
    import mips_pkg::*;
(
    input  logic [REG_ADDR_W-1:0] id_src1,
    input  logic [REG_ADDR_W-1:0] id_src2,
    input  logic                  id_two_src,
    input  logic [REG_ADDR_W-1:0] exe_dest,
    input  logic                  exe_wb_en,
    input  logic                  exe_mem_r_en,
    input  logic [REG_ADDR_W-1:0] mem_dest,
    input  logic                  mem_wb_en,
    input  logic                  forward_en,
    output logic                  hazard
);

    logic exe_live;
    logic mem_live;
    logic exe_match;
    logic mem_match;

    // Writes to r0 are discarded by the register file, so they never create a dependency.
    assign exe_live  = exe_wb_en && (exe_dest != ZERO_REG);
    assign mem_live  = mem_wb_en && (mem_dest != ZERO_REG);

    assign exe_match = exe_live && ((id_src1 == exe_dest) || (id_two_src && (id_src2 == exe_dest)));
    assign mem_match = mem_live && ((id_src1 == mem_dest) || (id_two_src && (id_src2 == mem_dest)));

    // With forwarding only a load in EXE cannot supply its result in time.
    assign hazard = forward_en ? (exe_match && exe_mem_r_en) : (exe_match || mem_match);

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Central stall/flush controller for the 5-stage MIPS pipeline: memory-access
// sequencing, branch flush, data-hazard bubbles and saturating perf counters.
module pipeline_hazard_ctrl
    import mips_pkg::*;
#(
    parameter int MEM_LATENCY = 4,
    parameter int CNT_W       = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [REG_ADDR_W-1:0] id_src1,
    input  logic [REG_ADDR_W-1:0] id_src2,
    input  logic                  id_two_src,
    input  logic [REG_ADDR_W-1:0] exe_dest,
    input  logic                  exe_wb_en,
    input  logic                  exe_mem_r_en,
    input  logic [REG_ADDR_W-1:0] mem_dest,
    input  logic                  mem_wb_en,
    input  logic                  forward_en,
    input  logic                  branch_taken,
    input  logic                  mem_req,
    output logic                  freeze_if,
    output logic                  freeze_id,
    output logic                  freeze_exe,
    output logic                  freeze_mem,
    output logic                  bubble_id,
    output logic                  flush_if,
    output logic [CNT_W-1:0]      stall_cycles,
    output logic [CNT_W-1:0]      flush_count
);

    localparam int LAT_W = 4;
    localparam logic [LAT_W-1:0] LAT_LOAD = LAT_W'(MEM_LATENCY - 1);

    mem_state_t       state;
    mem_state_t       state_nxt;
    logic [LAT_W-1:0] lat_cnt;
    logic [LAT_W-1:0] lat_cnt_nxt;
    logic             mem_stall;
    logic             hazard;

    hazard_detect u_hazard_detect (
        .id_src1      (id_src1),
        .id_src2      (id_src2),
        .id_two_src   (id_two_src),
        .exe_dest     (exe_dest),
        .exe_wb_en    (exe_wb_en),
        .exe_mem_r_en (exe_mem_r_en),
        .mem_dest     (mem_dest),
        .mem_wb_en    (mem_wb_en),
        .forward_en   (forward_en),
        .hazard       (hazard)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            lat_cnt <= '0;
        end else begin
            state   <= state_nxt;
            lat_cnt <= lat_cnt_nxt;
        end
    end

    // lat_cnt holds the WAIT cycles still to go, so IDLE + WAIT cycles total MEM_LATENCY.
    always_comb begin
        state_nxt   = state;
        lat_cnt_nxt = lat_cnt;
        mem_stall   = 1'b0;
        case (state)
            IDLE: begin
                if (mem_req) begin
                    mem_stall   = 1'b1;
                    lat_cnt_nxt = LAT_LOAD;
                    state_nxt   = (MEM_LATENCY > 1) ? WAIT : DONE;
                end
            end
            WAIT: begin
                mem_stall   = 1'b1;
                lat_cnt_nxt = lat_cnt - LAT_W'(1);
                if (lat_cnt <= LAT_W'(1)) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_comb begin
        freeze_if  = 1'b0;
        freeze_id  = 1'b0;
        freeze_exe = 1'b0;
        freeze_mem = 1'b0;
        bubble_id  = 1'b0;
        flush_if   = 1'b0;
        if (rst) begin
            freeze_if = 1'b0;
        end else if (mem_stall) begin
            freeze_if  = 1'b1;
            freeze_id  = 1'b1;
            freeze_exe = 1'b1;
            freeze_mem = 1'b1;
        end else if (branch_taken) begin
            flush_if  = 1'b1;
            bubble_id = 1'b1;
        end else if (hazard) begin
            freeze_if = 1'b1;
            bubble_id = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cycles <= '0;
            flush_count  <= '0;
        end else begin
            if (freeze_if && (stall_cycles != '1)) begin
                stall_cycles <= stall_cycles + CNT_W'(1);
            end
            if (flush_if && (flush_count != '1)) begin
                flush_count <= flush_count + CNT_W'(1);
            end
        end
    end

endmodule
